uart_rx_ext: RTL and testbench
==============================

Name: uart_rx_ext

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver.
- Configurable data width, parity mode and stop-bit count.
- 3-sample majority voting at each bit sample point, plus false-start rejection.
- Per-word framing/parity error flags and a receive FIFO with pop handshake and sticky overrun.
- Sits between the ICEstick Rx pin and the sniffer's command/packet logic.

Parameters:
BAUDS, 104, clocks per bit; must be >=8.
DATA_BITS, 8, data bits per frame, 5..9, LSB first.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits, 1 or 2.
FIFO_DEPTH, 4, receive FIFO entries; power of 2, >=2.

Ports:
clk  in  1  system clock; sole clock domain.
rst  in  1  asynchronous, active-low reset.
Rx  in  1  serial line; idle high; asynchronous to clk.
I_RD  in  1  pop FIFO head; ignored when empty.
I_CLR_OVR  in  1  clears O_OVR.
O_DATA  out  DATA_BITS  FIFO head data (first-word fall-through).
O_FERR  out  1  framing-error flag of head word.
O_PERR  out  1  parity-error flag of head word; 0 when PARITY=0.
O_VALID  out  1  FIFO not empty.
O_FULL  out  1  FIFO full.
O_OVR  out  1  sticky overrun flag.
NrD  out  1  1-cycle pulse per word accepted into the FIFO.
clk_Rx  out  1  1-cycle strobe at every bit sample point (debug).

Behaviour:
Reset:
- Reset is asynchronous, active-low; all state is cleared immediately.
- Output reset values: O_DATA=0, O_FERR=0, O_PERR=0, O_VALID=0, O_FULL=0, O_OVR=0, NrD=0, clk_Rx=0.
- Synchroniser flops and the 3-sample history reset to 1. FSM resets to IDLE; FIFO resets to empty.
- Reset mid-frame aborts the frame; no partial word is ever pushed.

Input sampling:
- Rx passes through a 2-flop synchroniser.
- A 3-entry shift history of synchronised samples is updated every clk.
- Sampled bit value = majority of the history at the sample point.

FSM states and transitions:
- IDLE: falling edge on synchronised Rx (previous 1, current 0) -> START; bit counter cleared.
- START: at counter = BAUDS/2 - 1, pulse clk_Rx and vote.
  - Vote 1 -> false start -> IDLE.
  - Vote 0 -> DATA; counter cleared.
- DATA: counter wraps at BAUDS-1; each wrap is a sample point (clk_Rx pulse).
  - Voted bit is shifted in LSB first.
  - After DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
- PARITY: one sample.
  - perr = (sampled bit != expected). Expected even bit = XOR of data bits; odd = its inverse.
- STOP: STOP_BITS samples; ferr = 1 if any sampled stop bit is 0.
  - At the last stop sample, push {perr, ferr, data} and go to IDLE in the same cycle.
  - A new start edge in the second half of the stop bit is therefore accepted.
- Break (Rx held low): frame completes with ferr=1. No further frame starts until Rx has returned high.

Latency (8N1):
- NrD pulses 9.5*BAUDS cycles after the Rx falling edge, tolerance +0/+4 cycles (synchroniser plus edge detection).

FIFO:
- Push with FIFO not full: word stored, NrD pulses.
- Push with FIFO full and no same-cycle pop: word dropped, NrD stays low, O_OVR set.
- Push and pop in the same cycle while full: both take effect; count unchanged; NrD pulses.
- Pop while empty: ignored.
- Head outputs (O_DATA, O_FERR, O_PERR) hold when O_VALID=0.
- Pointers wrap modulo FIFO_DEPTH.
- O_OVR is sticky: cleared by I_CLR_OVR or reset. If a set event and I_CLR_OVR occur in the same cycle, set wins.

Decomposition:
- Package uart_pkg holds:
  - parity mode constants: PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - FSM state encoding: IDLE, START, DATA, PARITY, STOP;
  - a function returning the FIFO word width, DATA_BITS+2;
  - a clog2 helper.
- One sub-module, uart_rx_fifo: synchronous FIFO with parametrised width and depth, first-word fall-through, full/empty, simultaneous push/pop.
- FSM, synchroniser and voter stay in uart_rx_ext.

Test Plan:
1. Defaults: send frame 0x69 (bits 1,0,0,1,0,1,1,0) -> one NrD within 9.5*104+0..4 cycles of the start edge; O_DATA=0x69, O_FERR=0, O_PERR=0, O_VALID=1. Pop -> O_VALID=0.
2. Back-to-back 0xFF then 0x69, no pop -> O_DATA=0xFF. Pop -> 0x69. Pop -> O_VALID=0.
3. Drive rst low during data bit 3 of 0xFF, release at bit 6 -> no NrD, all outputs at reset values. Next clean 0x69 is received correctly.
4. Glitches:
   - Rx low for 20 cycles in idle -> false start, no NrD.
   - Single-cycle inverted spike at a mid-bit sample point of 0x69 -> 0x69 still received.
5. PARITY=2, 0x69 sent with parity bit 1 -> O_PERR=1.
   STOP_BITS=2, second stop bit 0 -> O_FERR=1.
   Break: Rx held low for 20 bit times -> exactly one word, 0x00 with O_FERR=1.
6. FIFO_DEPTH=4, 5 frames with no pop:
   - O_FULL=1 after the fourth frame; fifth frame dropped with no NrD; O_OVR=1.
   - I_CLR_OVR -> O_OVR=0.
   - Pop coinciding with a push while full -> word accepted, O_FULL stays 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and sizing helpers for the UART receiver.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  // FIFO word is {perr, ferr, data}.
  function automatic int unsigned fifo_width(input int unsigned data_bits);
    return data_bits + 2;
  endfunction

  // Ceiling log2, never below 1 so derived vectors keep a legal width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word fall-through FIFO with simultaneous push/pop.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             push_ok_o
);

  localparam int unsigned AddrW = clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [AddrW:0]   cnt_q;
  logic             pop_ok;

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  always_comb begin
    empty_o   = (cnt_q == '0);
    full_o    = (cnt_q == (AddrW + 1)'(Depth));
    pop_ok    = pop_i & ~empty_o;
    push_ok_o = push_i & (~full_o | pop_ok);
    rdata_o   = mem_q[rptr_q];
  end

  // Storage, pointers and occupancy; Depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok_o) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + AddrW'(1);
      end
      if (pop_ok) rptr_q <= rptr_q + AddrW'(1);
      cnt_q <= cnt_q + (AddrW + 1)'(push_ok_o) - (AddrW + 1)'(pop_ok);
    end
  end

endmodule

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: synchroniser, 3-sample voter, framing FSM and receive FIFO.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int unsigned BAUDS      = 104,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Rx,
  input  logic                 I_RD,
  input  logic                 I_CLR_OVR,
  output logic [DATA_BITS-1:0] O_DATA,
  output logic                 O_FERR,
  output logic                 O_PERR,
  output logic                 O_VALID,
  output logic                 O_FULL,
  output logic                 O_OVR,
  output logic                 NrD,
  output logic                 clk_Rx
);

  localparam int unsigned CntW  = clog2(BAUDS);
  localparam int unsigned WordW = fifo_width(DATA_BITS);
  localparam int unsigned BitW  = 4;
  localparam logic [CntW-1:0] HalfCnt = CntW'(BAUDS / 2 - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(BAUDS - 1);
  localparam logic            ParOdd  = (PARITY == PAR_ODD);

  logic                 rx_meta_q, rx_sync_q;
  logic [2:0]           hist_q;
  logic                 vote, fall;
  rx_state_e            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d, ferr_now;
  logic                 sample, push, push_ok, empty, ovr_q;
  logic [WordW-1:0]     head;

  // Two-flop synchroniser plus 3-deep history; idle-high reset avoids a spurious start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      hist_q    <= 3'b111;
    end else begin
      rx_meta_q <= Rx;
      rx_sync_q <= rx_meta_q;
      hist_q    <= {hist_q[1:0], rx_sync_q};
    end
  end

  // Majority vote and start-edge detection.
  always_comb begin
    vote = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
    fall = hist_q[0] & ~rx_sync_q;
  end

  // Framing FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: bit timing, data shift-in, parity and stop checks, FIFO push.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CntW'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    ferr_now = ferr_q | ~vote;
    sample   = 1'b0;
    push     = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (fall) begin
          state_d = StStart;
          bit_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      StStart: begin
        if (cnt_q == HalfCnt) begin
          sample  = 1'b1;
          cnt_d   = '0;
          // A high vote at mid start bit is a glitch, not a frame.
          state_d = vote ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == FullCnt) begin
          sample  = 1'b1;
          cnt_d   = '0;
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (bit_q == BitW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? StParity : StStop;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      StParity: begin
        if (cnt_q == FullCnt) begin
          sample  = 1'b1;
          cnt_d   = '0;
          perr_d  = vote ^ (^shift_q) ^ ParOdd;
          state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == FullCnt) begin
          sample = 1'b1;
          cnt_d  = '0;
          ferr_d = ferr_now;
          if (bit_q == BitW'(STOP_BITS - 1)) begin
            // Back to idle at the stop sample so an early next start edge is caught.
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  uart_rx_fifo #(
    .Width(WordW),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk),
    .rst_ni   (rst),
    .push_i   (push),
    .wdata_i  ({perr_q, ferr_now, shift_q}),
    .pop_i    (I_RD),
    .rdata_o  (head),
    .empty_o  (empty),
    .full_o   (O_FULL),
    .push_ok_o(push_ok)
  );

  // Sticky overrun: a dropped word outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr_q <= 1'b0;
    end else if (push && !push_ok) begin
      ovr_q <= 1'b1;
    end else if (I_CLR_OVR) begin
      ovr_q <= 1'b0;
    end
  end

  // Output mapping.
  always_comb begin
    {O_PERR, O_FERR, O_DATA} = head;
    O_VALID = ~empty;
    O_OVR   = ovr_q;
    NrD     = push_ok;
    clk_Rx  = sample;
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Self-checking bench: 8N1 receiver (dut0) and even-parity, 2-stop receiver (dut1).
module tb_uart_rx_ext;

  localparam int unsigned BAUDS = 104;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1;
  logic rd0 = 1'b0, rd1 = 1'b0, clr0 = 1'b0, clr1 = 1'b0;
  logic [7:0] data0, data1;
  logic ferr0, perr0, valid0, full0, ovr0, nrd0, clkrx0;
  logic ferr1, perr1, valid1, full1, ovr1, nrd1, clkrx1;

  int n_pass = 0, n_fail = 0, n_total = 0;
  int cyc = 0;
  int nrd_cnt0 = 0, nrd_cnt1 = 0, nrd_cyc0 = 0;

  // Reference model: queues of {perr, ferr, data} words and sticky overrun flags.
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic       movr0 = 1'b0, movr1 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #2;
    if (nrd0) begin
      nrd_cnt0++;
      nrd_cyc0 = cyc;
    end
    if (nrd1) nrd_cnt1++;
  end

  uart_rx_ext #(
    .BAUDS(BAUDS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) dut0 (
    .clk(clk), .rst(rst), .Rx(rx0), .I_RD(rd0), .I_CLR_OVR(clr0),
    .O_DATA(data0), .O_FERR(ferr0), .O_PERR(perr0), .O_VALID(valid0),
    .O_FULL(full0), .O_OVR(ovr0), .NrD(nrd0), .clk_Rx(clkrx0)
  );

  uart_rx_ext #(
    .BAUDS(BAUDS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)
  ) dut1 (
    .clk(clk), .rst(rst), .Rx(rx1), .I_RD(rd1), .I_CLR_OVR(clr1),
    .O_DATA(data1), .O_FERR(ferr1), .O_PERR(perr1), .O_VALID(valid1),
    .O_FULL(full1), .O_OVR(ovr1), .NrD(nrd1), .clk_Rx(clkrx1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void mpush0(input logic [9:0] w);
    if (q0.size() < DEPTH) q0.push_back(w);
    else movr0 = 1'b1;
  endfunction

  function automatic void mpush1(input logic [9:0] w);
    if (q1.size() < DEPTH) q1.push_back(w);
    else movr1 = 1'b1;
  endfunction

  task automatic bit0(input logic b, input int n);
    rx0 = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic bit1(input logic b, input int n);
    rx1 = b;
    repeat (n) @(negedge clk);
  endtask

  // 8N1 frame; spike_bit selects a data bit that gets a one-cycle inverted spike (-1: none).
  task automatic frame0(input logic [7:0] d, input int spike_bit);
    bit0(1'b0, BAUDS);
    for (int i = 0; i < 8; i++) begin
      if (i == spike_bit) begin
        bit0(d[i], BAUDS / 2 - 1);
        bit0(~d[i], 1);
        bit0(d[i], BAUDS / 2);
      end else begin
        bit0(d[i], BAUDS);
      end
    end
    bit0(1'b1, BAUDS);
  endtask

  task automatic frame1(input logic [7:0] d, input logic pbit, input logic s1, input logic s2);
    bit1(1'b0, BAUDS);
    for (int i = 0; i < 8; i++) bit1(d[i], BAUDS);
    bit1(pbit, BAUDS);
    bit1(s1, BAUDS);
    bit1(s2, BAUDS);
    bit1(1'b1, BAUDS);
  endtask

  task automatic pop0();
    rd0 = 1'b1;
    @(negedge clk);
    rd0 = 1'b0;
    if (q0.size() > 0) void'(q0.pop_front());
  endtask

  task automatic pop1();
    rd1 = 1'b1;
    @(negedge clk);
    rd1 = 1'b0;
    if (q1.size() > 0) void'(q1.pop_front());
  endtask

  task automatic check_head0(input string tag);
    check({tag, "_valid0"}, 32'(valid0), 32'(q0.size() != 0));
    check({tag, "_full0"}, 32'(full0), 32'(q0.size() == DEPTH));
    check({tag, "_ovr0"}, 32'(ovr0), 32'(movr0));
    if (q0.size() != 0) check({tag, "_head0"}, 32'({perr0, ferr0, data0}), 32'(q0[0]));
  endtask

  task automatic check_head1(input string tag);
    check({tag, "_valid1"}, 32'(valid1), 32'(q1.size() != 0));
    check({tag, "_ovr1"}, 32'(ovr1), 32'(movr1));
    if (q1.size() != 0) check({tag, "_head1"}, 32'({perr1, ferr1, data1}), 32'(q1[0]));
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_data"}, 32'(data0), 32'h0);
    check({tag, "_flags"}, 32'({ferr0, perr0, valid0, full0, ovr0}), 32'h0);
    check({tag, "_strobes"}, 32'({nrd0, clkrx0, nrd1, clkrx1}), 32'h0);
    check({tag, "_dut1"}, 32'({data1, ferr1, perr1, valid1, full1, ovr1}), 32'h0);
  endtask

  initial begin
    int base, start, lat, hits, tmo;
    logic [7:0] d;
    logic pb, s1, s2, perr_e;

    // Reset values
    repeat (3) @(negedge clk);
    check_reset_outs("rst");
    rst = 1'b1;
    repeat (2 * BAUDS) @(negedge clk);

    // 1: single 0x69 frame and its latency
    base  = nrd_cnt0;
    start = cyc;
    frame0(8'h69, -1);
    mpush0({2'b00, 8'h69});
    check("t1_nrd", nrd_cnt0 - base, 1);
    lat = nrd_cyc0 - start;
    check("t1_lat_lo", 32'(lat >= 988), 1);
    check("t1_lat_hi", 32'(lat <= 992), 1);
    check_head0("t1");
    pop0();
    check_head0("t1_pop");

    // 2: back-to-back frames, FIFO order
    frame0(8'hFF, -1);
    mpush0({2'b00, 8'hFF});
    frame0(8'h69, -1);
    mpush0({2'b00, 8'h69});
    check_head0("t2_a");
    pop0();
    check_head0("t2_b");
    pop0();
    check_head0("t2_c");

    // 3: reset asserted mid-frame (bit 3) and released at bit 6
    base = nrd_cnt0;
    bit0(1'b0, BAUDS);
    for (int i = 0; i < 3; i++) bit0(1'b1, BAUDS);
    bit0(1'b1, BAUDS / 2);
    rst = 1'b0;
    q0.delete();
    q1.delete();
    movr0 = 1'b0;
    movr1 = 1'b0;
    bit0(1'b1, BAUDS / 2 + 2 * BAUDS + BAUDS / 2);
    check_reset_outs("t3_in");
    rst = 1'b1;
    bit0(1'b1, BAUDS / 2 + 2 * BAUDS);
    check("t3_nrd", nrd_cnt0 - base, 0);
    check_reset_outs("t3_after");
    frame0(8'h69, -1);
    mpush0({2'b00, 8'h69});
    check_head0("t3_next");
    pop0();

    // 4: false start and a mid-bit spike
    base = nrd_cnt0;
    bit0(1'b0, 20);
    bit0(1'b1, 2 * BAUDS);
    check("t4_false_nrd", nrd_cnt0 - base, 0);
    check_head0("t4_false");
    frame0(8'h69, 3);
    mpush0({2'b00, 8'h69});
    check("t4_spike_nrd", nrd_cnt0 - base, 1);
    check_head0("t4_spike");
    pop0();

    // 5: parity error, second stop bit low, break
    base = nrd_cnt1;
    frame1(8'h69, 1'b1, 1'b1, 1'b1);
    mpush1({2'b10, 8'h69});
    check_head1("t5_perr");
    pop1();
    frame1(8'h69, 1'b0, 1'b1, 1'b0);
    mpush1({2'b01, 8'h69});
    check_head1("t5_ferr");
    pop1();
    check("t5_nrd1", nrd_cnt1 - base, 2);
    base = nrd_cnt0;
    bit0(1'b0, 20 * BAUDS);
    bit0(1'b1, 2 * BAUDS);
    mpush0({2'b01, 8'h00});
    check("t5_break_nrd", nrd_cnt0 - base, 1);
    check_head0("t5_break");
    pop0();

    // 6: fill, overrun, clear, push coinciding with pop while full
    for (int i = 1; i <= 4; i++) begin
      frame0(8'(i * 8'h11), -1);
      mpush0({2'b00, 8'(i * 8'h11)});
    end
    check_head0("t6_full");
    base = nrd_cnt0;
    frame0(8'h55, -1);
    mpush0({2'b00, 8'h55});
    check("t6_drop_nrd", nrd_cnt0 - base, 0);
    check_head0("t6_ovr");
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    movr0 = 1'b0;
    check_head0("t6_clr");
    base = nrd_cnt0;
    hits = 0;
    fork
      frame0(8'h66, -1);
      begin
        tmo = 0;
        while (hits < 10 && tmo < 2000) begin
          @(negedge clk);
          tmo++;
          if (clkrx0) hits++;
        end
        if (hits == 10) begin
          rd0 = 1'b1;
          @(negedge clk);
          rd0 = 1'b0;
        end
      end
    join
    check("t6_strobes", hits, 10);
    void'(q0.pop_front());
    mpush0({2'b00, 8'h66});
    check("t6_pp_nrd", nrd_cnt0 - base, 1);
    check_head0("t6_pp");
    for (int i = 0; i < 4; i++) begin
      pop0();
      check_head0("t6_drain");
    end

    // Randomised 8N1 frames with random pops; overruns may occur
    for (int i = 0; i < 7; i++) begin
      d = 8'($urandom);
      frame0(d, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
      mpush0({2'b00, d});
      check_head0("rnd0");
      if ($urandom_range(0, 2) == 0) pop0();
    end
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    movr0 = 1'b0;
    while (q0.size() > 0) begin
      pop0();
      check_head0("rnd0_drain");
    end

    // Randomised parity/stop frames on the even-parity, 2-stop receiver
    for (int i = 0; i < 6; i++) begin
      d  = 8'($urandom);
      pb = 1'($urandom);
      s1 = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 3) != 0);
      perr_e = pb ^ (^d);
      frame1(d, pb, s1, s2);
      mpush1({perr_e, ~(s1 & s2), d});
      check_head1("rnd1");
      pop1();
    end
    check_head1("rnd1_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
